// File: rtl/fifo_pkg.sv
// Shared constants and word type for the 64x22 first-word-fall-through FIFO.
package fifo_pkg;

    localparam int FIFO_DEPTH = 64;
    localparam int FIFO_AW    = 6;
    localparam int FIFO_WIDTH = 22;
    localparam int FIFO_HALF  = 32;

    typedef logic [FIFO_WIDTH-1:0] fifo_word_t;

    // Occupancy seen by the outside world: RAM words, the word in flight, and the output stage.
    function automatic logic [6:0] fifo_total(input logic [6:0] ram_cnt,
                                              input logic       pending,
                                              input logic [1:0] stage_cnt);
        return ram_cnt + {6'd0, pending} + {5'd0, stage_cnt};
    endfunction

endpackage

// File: rtl/rf_2p_64x22.sv
// Behavioural model of the 64x22 two-port register file macro: port A reads, port B writes, active-low enables.
module rf_2p_64x22 (
    input  logic        CLKA,
    input  logic        CENA,
    input  logic [5:0]  AA,
    output logic [21:0] QA,
    input  logic        CLKB,
    input  logic        CENB,
    input  logic [5:0]  AB,
    input  logic [21:0] DB
);

    logic [21:0] mem_q [64];

    always_ff @(posedge CLKA) begin
        if (!CENA) begin
            QA <= mem_q[AA];
        end
    end

    always_ff @(posedge CLKB) begin
        if (!CENB) begin
            mem_q[AB] <= DB;
        end
    end

endmodule

// File: rtl/fifo_64x22.sv
// 64x22 FIFO over rf_2p_64x22 with a 2-entry prefetch output stage that hides the RAM read latency.
module fifo_64x22
    import fifo_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [21:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [21:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [6:0]  fifo_counter,
    output logic        fifo_empty,
    output logic        fifo_half,
    output logic        fifo_full,
    output logic        fifo_overflow
);

    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [6:0]         ram_count_q, ram_count_d;
    logic               rd_pending_q, rd_pending_d;
    logic [1:0]         stage_count_q, stage_count_d;
    fifo_word_t         head_q, head_d;
    fifo_word_t         tail_q, tail_d;
    logic [6:0]         fifo_counter_q, fifo_counter_d;
    logic               in_ready_q, in_ready_d;
    logic               fifo_empty_q, fifo_empty_d;
    logic               fifo_half_q, fifo_half_d;
    logic               overflow_q, overflow_d;

    logic               push;
    logic               pop;
    logic               rd_issue;
    logic [1:0]         stage_after_pop;

    logic               ram_cena;
    logic               ram_cenb;
    logic [FIFO_AW-1:0] ram_aa;
    logic [FIFO_AW-1:0] ram_ab;
    fifo_word_t         ram_db;
    fifo_word_t         ram_qa;

    rf_2p_64x22 u_ram (
        .CLKA (clk),
        .CENA (ram_cena),
        .AA   (ram_aa),
        .QA   (ram_qa),
        .CLKB (clk),
        .CENB (ram_cenb),
        .AB   (ram_ab),
        .DB   (ram_db)
    );

    // Issue decisions: reset forces both RAM enables inactive.
    always_comb begin
        push            = in_valid & in_ready_q & ~reset;
        pop             = (stage_count_q != 2'd0) & out_ready;
        stage_after_pop = stage_count_q - {1'b0, pop};
        // Only committed words are read, so the read never races the same-edge write.
        rd_issue        = ~reset & (ram_count_q != 7'd0)
                        & ((stage_after_pop + {1'b0, rd_pending_q}) < 2'd2);

        ram_cenb = ~push;
        ram_ab   = wr_ptr_q;
        ram_db   = in_data;
        ram_cena = ~rd_issue;
        ram_aa   = rd_ptr_q;
    end

    // Next state: pointers, counts and the output stage.
    always_comb begin
        wr_ptr_d      = wr_ptr_q + FIFO_AW'(push);
        rd_ptr_d      = rd_ptr_q + FIFO_AW'(rd_issue);
        ram_count_d   = ram_count_q + 7'(push) - 7'(rd_issue);
        rd_pending_d  = rd_issue;

        head_d        = head_q;
        tail_d        = tail_q;
        if (pop) begin
            head_d = tail_q;
        end
        if (rd_pending_q) begin
            if (stage_after_pop == 2'd0) begin
                head_d = ram_qa;
            end else begin
                tail_d = ram_qa;
            end
        end
        stage_count_d = stage_after_pop + {1'b0, rd_pending_q};

        fifo_counter_d = fifo_total(ram_count_d, rd_pending_d, stage_count_d);
        in_ready_d     = ram_count_d < 7'(FIFO_DEPTH);
        fifo_empty_d   = fifo_counter_d == 7'd0;
        fifo_half_d    = fifo_counter_d >= 7'(FIFO_HALF);
        overflow_d     = overflow_q | (in_valid & ~in_ready_q);
    end

    // Registered state; an in-flight QA is dropped because rd_pending clears with reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            ram_count_q    <= '0;
            rd_pending_q   <= 1'b0;
            stage_count_q  <= '0;
            head_q         <= '0;
            fifo_counter_q <= '0;
            in_ready_q     <= 1'b1;
            fifo_empty_q   <= 1'b1;
            fifo_half_q    <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            ram_count_q    <= ram_count_d;
            rd_pending_q   <= rd_pending_d;
            stage_count_q  <= stage_count_d;
            head_q         <= head_d;
            fifo_counter_q <= fifo_counter_d;
            in_ready_q     <= in_ready_d;
            fifo_empty_q   <= fifo_empty_d;
            fifo_half_q    <= fifo_half_d;
            overflow_q     <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        tail_q <= tail_d;
    end

    assign in_ready      = in_ready_q;
    assign out_data      = head_q;
    assign out_valid     = stage_count_q != 2'd0;
    assign fifo_counter  = fifo_counter_q;
    assign fifo_empty    = fifo_empty_q;
    assign fifo_half     = fifo_half_q;
    assign fifo_full     = ~in_ready_q;
    assign fifo_overflow = overflow_q;

endmodule

// File: tb/tb_fifo_64x22.sv
// Scoreboard bench for fifo_64x22: accepted pushes are queued, every pop is checked against the queue head.
module tb_fifo_64x22;

    logic        clk = 1'b0;
    logic        reset;
    logic [21:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [21:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  fifo_counter;
    logic        fifo_empty;
    logic        fifo_half;
    logic        fifo_full;
    logic        fifo_overflow;

    int          total = 0;
    int          bad   = 0;
    logic [21:0] sb_q[$];
    logic        exp_ovf = 1'b0;
    logic        chk_full = 1'b0;

    fifo_64x22 dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .fifo_counter  (fifo_counter),
        .fifo_empty    (fifo_empty),
        .fifo_half     (fifo_half),
        .fifo_full     (fifo_full),
        .fifo_overflow (fifo_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // One clock: checks status from the last edge, applies inputs, books push/pop, then waits past the edge.
    task automatic cycle(input logic v, input logic [21:0] d, input logic r);
        logic [21:0] exp_word;
        @(negedge clk);
        check("count", {25'd0, fifo_counter}, sb_q.size());
        check("empty", {31'd0, fifo_empty}, {31'd0, sb_q.size() == 0});
        check("half", {31'd0, fifo_half}, {31'd0, sb_q.size() >= 32});
        check("ovf", {31'd0, fifo_overflow}, {31'd0, exp_ovf});
        if (chk_full) check("full", {31'd0, fifo_full}, {31'd0, sb_q.size() == 66});
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("spurious pop", 32'd1, 32'd0);
            end else begin
                exp_word = sb_q.pop_front();
                check("data", {10'd0, out_data}, {10'd0, exp_word});
            end
        end
        if (in_valid) begin
            if (in_ready) sb_q.push_back(in_data);
            else exp_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            cycle(1'b0, 22'd0, 1'b1);
            n++;
        end
        check("drain left", sb_q.size(), 32'd0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready", {31'd0, in_ready}, 32'd1);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst counter", {25'd0, fifo_counter}, 32'd0);
        check("rst empty", {31'd0, fifo_empty}, 32'd1);
        check("rst out_data", {10'd0, out_data}, 32'd0);
        check("rst ovf", {31'd0, fifo_overflow}, 32'd0);
        check("rst full", {31'd0, fifo_full}, 32'd0);
        in_valid = 1'b1; #1;
        check("rst cena", {31'd0, dut.ram_cena}, 32'd1);
        check("rst cenb", {31'd0, dut.ram_cenb}, 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // single push and first-word latency
        cycle(1'b1, 22'h00000F, 1'b0);
        cycle(1'b0, 22'd0, 1'b0);
        check("lat out_valid early", {31'd0, out_valid}, 32'd0);
        cycle(1'b0, 22'd0, 1'b0);
        check("lat out_valid", {31'd0, out_valid}, 32'd1);
        check("lat out_data", {10'd0, out_data}, 32'h00000F);
        cycle(1'b0, 22'd0, 1'b1);
        check("single empty", {31'd0, fifo_empty}, 32'd1);

        // streaming 0..199
        for (int i = 0; i < 200; i++) begin
            cycle(1'b1, 22'(i), 1'b1);
            if (i >= 2) begin
                check("stream vld", {31'd0, out_valid}, 32'd1);
                check("stream cnt<=3", {31'd0, fifo_counter <= 7'd3}, 32'd1);
            end
        end
        drain(20);

        // fill to full plus one dropped push
        chk_full = 1'b1;
        for (int i = 0; i < 67; i++) cycle(1'b1, 22'h00ABC0 + 22'(i), 1'b0);
        check("fill counter", {25'd0, fifo_counter}, 32'd66);
        check("fill full", {31'd0, fifo_full}, 32'd1);
        check("fill ovf", {31'd0, fifo_overflow}, 32'd1);
        check("fill half", {31'd0, fifo_half}, 32'd1);
        drain(200);
        chk_full = 1'b0;
        check("ovf sticky", {31'd0, fifo_overflow}, 32'd1);

        // fill/drain rounds with random back-pressure across pointer wrap
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 120; i++)
                cycle(1'b1, 22'($urandom), 1'($urandom_range(0, 1)));
            for (int i = 0; i < 60; i++)
                cycle(1'b0, 22'd0, 1'($urandom_range(0, 1)));
            drain(200);
        end

        // reset with 40 words held and a read in flight
        for (int i = 0; i < 40; i++) cycle(1'b1, 22'h100 + 22'(i), 1'b0);
        cycle(1'b0, 22'd0, 1'b1);
        check("pre-rst pending", {31'd0, dut.rd_pending_q}, 32'd1);
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        check("mid rst counter", {25'd0, fifo_counter}, 32'd0);
        check("mid rst out_valid", {31'd0, out_valid}, 32'd0);
        check("mid rst empty", {31'd0, fifo_empty}, 32'd1);
        check("mid rst ovf", {31'd0, fifo_overflow}, 32'd0);
        sb_q.delete();
        exp_ovf = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        cycle(1'b1, 22'h3FFFFF, 1'b0);
        cycle(1'b0, 22'd0, 1'b0);
        cycle(1'b0, 22'd0, 1'b0);
        check("post rst vld", {31'd0, out_valid}, 32'd1);
        check("post rst data", {10'd0, out_data}, 32'h3FFFFF);
        drain(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
